dbus_wb_master: RTL and testbench
=================================

Name: dbus_wb_master

Overview:
- Wishbone master that converts the MiniMIPS32 data-memory port (load/store from MEM stage) into single Wishbone classic cycles.
- Drives the peripheral/memory slaves on the shared bus (LED, seven-segment, switch, key, timer decoder) and returns read data to the CPU.
- Stalls the pipeline for the duration of each access and handles pipeline flushes and an ack timeout.

Parameters:
- TO_WIDTH, 8, width of the ack-timeout counter. An access aborts after 2^TO_WIDTH-1 cycles in BUS without ack.
- ERR_RDATA, 32'h00000000, read data returned to the CPU on a timed-out access.

Ports:
- wb_clk_i  in  1  clock for all logic.
- wb_rst_i  in  1  reset. Synchronous, active-high.
- cpu_ce  in  1  CPU data access request (level; held while stalled).
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  32  byte address.
- cpu_sel  in  4  byte lane enables.
- cpu_wdata  in  32  store data, already lane-aligned.
- cpu_rdata  out  32  load data, full word; valid in HOLD.
- flush  in  1  pipeline flush (exception/eret); kills the current request.
- stall_req  out  1  combinational stall request to the pipeline controller.
- bus_err  out  1  one-cycle pulse when an access timed out.
- wb_cyc_o  out  1  cycle valid.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  32  address; cpu_addr[31:2] with 2'b00 appended.
- wb_sel_o  out  4  byte selects.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  slave ack; may be combinational from cyc&stb.

Behaviour:
- Reset (wb_rst_i=1 at a clock edge):
  - state=IDLE; cyc, stb, we, adr, sel, dat_o, cpu_rdata, bus_err, timeout counter and discard flag all 0.
  - stall_req is forced 0 while wb_rst_i=1.
  - Reset mid-access drops cyc/stb at the next edge; no ack is honoured afterwards.
- All Wishbone outputs are registered.
- stall_req = cpu_ce & ~flush & (state != HOLD) & ~wb_rst_i.
- IDLE:
  - If cpu_ce & ~flush: latch we/adr/sel/dat_o from the CPU, assert cyc=stb=1 at the next edge, clear the counter and discard flag, go to BUS.
  - Otherwise stay in IDLE with cyc=stb=0.
- BUS:
  - cyc, stb, adr, we, sel and dat_o are held stable.
  - Counter increments each cycle without ack.
  - flush in BUS sets discard=1. The bus cycle is never aborted early.
  - On wb_ack_i=1:
    - cyc=stb=0 at the next edge.
    - If ~we, capture wb_dat_i into cpu_rdata.
    - Next state is HOLD if discard=0 (and flush=0 this cycle); otherwise IDLE with cpu_rdata unchanged.
  - Counter reaching all-ones without ack:
    - cyc=stb=0 at the next edge.
    - If ~we, cpu_rdata=ERR_RDATA.
    - bus_err=1 for exactly the next cycle.
    - Next state is HOLD, or IDLE if discarded; bus_err still pulses.
  - Ack and timeout in the same cycle: ack wins, no bus_err.
- HOLD:
  - Lasts exactly one cycle. stall_req=0, so the pipeline advances and cpu_rdata is sampled.
  - Returns to IDLE unconditionally. flush in HOLD has no effect.
  - No new cycle starts from HOLD. A request present in the following cycle starts from IDLE.
- Latency with a combinational-ack slave:
  - Request seen in cycle 0, cyc/stb high in cycle 1, ack in cycle 1.
  - HOLD in cycle 2 with cpu_rdata valid, so stall lasts cycles 0-1.
  - Each added ack wait state adds one cycle.
- Back-to-back accesses: minimum 3 cycles per access; cyc/stb is low for at least one cycle between cycles.
- cpu_rdata holds its last value outside HOLD.

Test Plan:
- Load from 0x1FD0F020 with switch=0xA5 and combinational ack:
  - cyc/stb high cycle 1 only, adr=0x1FD0F020, sel as driven, we=0.
  - cpu_rdata=0x000000A5 in cycle 2.
  - stall_req=1 cycles 0-1, 0 in cycle 2.
- Store 0x0000BEEF to 0x1FD0F000, sel=4'hF:
  - we=1 and dat_o=0x0000BEEF held while cyc=1.
  - One ack completes it; the LED register reads back 0xBEEF.
- Slave delays ack by 3 cycles on a load returning 0x12345678:
  - adr/sel/we stay stable for 4 bus cycles.
  - HOLD in cycle 5 with cpu_rdata=0x12345678.
- Never ack, TO_WIDTH=4:
  - cyc drops after 15 BUS cycles.
  - bus_err pulses for one cycle, cpu_rdata=ERR_RDATA, then stall_req=0 for one cycle.
- Delayed-ack load with flush asserted in BUS cycle 2 and a new request presented:
  - The old cycle runs to ack; cpu_rdata is not updated and no HOLD occurs.
  - The new request stays stalled and starts its own cycle from IDLE.
- Reset asserted in BUS:
  - cyc/stb/we=0, bus_err=0 and stall_req=0 after the edge.
  - A late ack is ignored and the next request starts cleanly.

Source files
------------

// File: rtl/dbus_wb_master.sv
// Wishbone classic master for the MiniMIPS32 data-memory port: one bus cycle per
// load/store, with pipeline stall, flush-discard and ack-timeout handling.
module dbus_wb_master #(
  parameter int          TO_WIDTH  = 8,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_ce,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_sel,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic        flush,
  output logic        stall_req,
  output logic        bus_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Timeout fires in the cycle whose increment would make the counter all-ones,
  // giving 2^TO_WIDTH-1 BUS cycles without ack before the abort.
  localparam logic [TO_WIDTH-1:0] TO_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};

  state_t              state, state_next;
  logic [TO_WIDTH-1:0] cnt;
  logic                discard;
  logic                start, ack_hit, timeout, drop;
  logic                unused_addr;

  assign unused_addr = ^cpu_addr[1:0];

  assign stall_req = cpu_ce & ~flush & (state != HOLD) & ~wb_rst_i;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    ack_hit    = 1'b0;
    timeout    = 1'b0;
    drop       = discard | flush;
    case (state)
      IDLE: begin
        if (cpu_ce && !flush) begin
          start      = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        if (wb_ack_i) begin
          ack_hit    = 1'b1;
          state_next = drop ? IDLE : HOLD;
        end else if (cnt == TO_LAST) begin
          timeout    = 1'b1;
          state_next = drop ? IDLE : HOLD;
        end
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_sel_o  <= '0;
      wb_dat_o  <= '0;
      cpu_rdata <= '0;
      bus_err   <= 1'b0;
      cnt       <= '0;
      discard   <= 1'b0;
    end else begin
      state   <= state_next;
      bus_err <= timeout;
      if (start) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= cpu_we;
        wb_adr_o <= {cpu_addr[31:2], 2'b00};
        wb_sel_o <= cpu_sel;
        wb_dat_o <= cpu_wdata;
        cnt      <= '0;
        discard  <= 1'b0;
      end
      if (state == BUS) begin
        if (ack_hit || timeout) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (flush) discard <= 1'b1;
      end
      // A discarded access still completes on the bus but never updates load data.
      if (ack_hit && !wb_we_o && !drop) cpu_rdata <= wb_dat_i;
      if (timeout && !wb_we_o && !drop) cpu_rdata <= ERR_RDATA;
    end
  end

endmodule

// File: tb/tb_dbus_wb_master.sv
// Bench for dbus_wb_master: behavioural slave (switch/LED/memory with programmable
// ack delay) and a scoreboard of expected load/store results.
module tb_dbus_wb_master;

  localparam logic [31:0] SW_ADDR  = 32'h1FD0_F020;
  localparam logic [31:0] LED_ADDR = 32'h1FD0_F000;
  localparam logic [31:0] ERR_VAL  = 32'hDEAD_0BAD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_ce = 1'b0, cpu_we = 1'b0, flush = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_sel = '0;
  logic [31:0] cpu_rdata;
  logic        stall_req, bus_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;

  logic [7:0]  sw = 8'h00;
  logic [31:0] led_reg;
  logic [31:0] mem_word = 32'h0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        never_ack = 1'b0, force_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  dbus_wb_master #(.TO_WIDTH(4), .ERR_RDATA(ERR_VAL)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_sel(cpu_sel),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .flush(flush),
    .stall_req(stall_req), .bus_err(bus_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always_comb begin
    if (wb_adr_o == SW_ADDR)       wb_dat_i = {24'h0, sw};
    else if (wb_adr_o == LED_ADDR) wb_dat_i = led_reg;
    else                           wb_dat_i = mem_word;
  end

  assign wb_ack_i = force_ack | (wb_cyc_o & wb_stb_o & ~never_ack & (wait_cnt == ack_delay));

  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) wait_cnt <= wait_cnt + 1;
    else                                   wait_cnt <= 0;
    if (rst) led_reg <= '0;
    else if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o && wb_adr_o == LED_ADDR)
      for (int b = 0; b < 4; b++)
        if (wb_sel_o[b]) led_reg[8*b +: 8] <= wb_dat_o[8*b +: 8];
  end

  task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wdata);
    @(posedge clk); #1;
    cpu_ce = 1'b1; cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_wdata = wdata;
  endtask

  // Waits for the HOLD cycle (stall released while requesting); lat is its cycle index.
  task automatic wait_hold(input int budget, output int lat, output bit done);
    done = 1'b0; lat = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!stall_req) begin done = 1'b1; lat = c; break; end
    end
  endtask

  task automatic end_req();
    @(posedge clk); #1;
    cpu_ce = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_ce = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, bus_err, wb_sel_o} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000000", {wb_cyc_o, wb_stb_o, wb_we_o, bus_err, wb_sel_o});
    end
    checks++;
    if ({wb_adr_o, wb_dat_o, cpu_rdata} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got %h %h %h want zeros", wb_adr_o, wb_dat_o, cpu_rdata);
    end
    @(posedge clk); #1;
    cpu_ce = 1'b0; rst = 1'b0;
  endtask

  task automatic test_load_switch();
    sw = 8'hA5; ack_delay = 0;
    drive(1'b0, SW_ADDR, 4'b0001, 32'h0);
    exp_q.push_back(32'h0000_00A5);
    @(negedge clk);
    checks++;
    if ({stall_req, wb_cyc_o, wb_stb_o} !== 3'b100) begin
      errors++; $display("FAIL load_c0: got %b want 100", {stall_req, wb_cyc_o, wb_stb_o});
    end
    @(negedge clk);
    checks++;
    if ({stall_req, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 8'b1110_0001) begin
      errors++; $display("FAIL load_c1_ctrl: got %b want 11100001", {stall_req, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o});
    end
    checks++;
    if (wb_adr_o !== SW_ADDR) begin errors++; $display("FAIL load_c1_adr: got %h want %h", wb_adr_o, SW_ADDR); end
    @(negedge clk);
    checks++;
    if ({stall_req, wb_cyc_o, wb_stb_o} !== 3'b000) begin
      errors++; $display("FAIL load_c2_hold: got %b want 000", {stall_req, wb_cyc_o, wb_stb_o});
    end
    exp = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== exp) begin errors++; $display("FAIL load_rdata: got %h want %h", cpu_rdata, exp); end
    end_req();
  endtask

  task automatic test_store_led();
    int lat; bit done;
    ack_delay = 0;
    drive(1'b1, LED_ADDR, 4'hF, 32'h0000_BEEF);
    exp_q.push_back(32'h0000_BEEF);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({wb_cyc_o, wb_we_o, wb_dat_o, wb_adr_o} !== {2'b11, 32'h0000_BEEF, LED_ADDR}) begin
      errors++; $display("FAIL store_c1: got %b %h %h want 11 0000beef %h", {wb_cyc_o, wb_we_o}, wb_dat_o, wb_adr_o, LED_ADDR);
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if ({stall_req, wb_cyc_o} !== 2'b00 || led_reg !== exp) begin
      errors++; $display("FAIL store_led: got %b %h want 00 %h", {stall_req, wb_cyc_o}, led_reg, exp);
    end
    end_req();
    exp_q.push_back(32'h0000_BEEF);
    drive(1'b0, LED_ADDR, 4'hF, 32'h0);
    wait_hold(10, lat, done);
    exp = exp_q.pop_front();
    checks++;
    if (!done || lat != 2 || cpu_rdata !== exp) begin
      errors++; $display("FAIL led_readback: got lat %0d data %h want lat 2 data %h", lat, cpu_rdata, exp);
    end
    end_req();
  endtask

  task automatic test_delayed_ack();
    int bus_cycles = 0, hold_at = -1;
    ack_delay = 3; mem_word = 32'h1234_5678;
    drive(1'b0, 32'h0000_1004, 4'b1100, 32'h0);
    exp_q.push_back(32'h1234_5678);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (wb_cyc_o) begin
        bus_cycles++;
        checks++;
        if (wb_adr_o !== 32'h0000_1004 || wb_sel_o !== 4'b1100 || wb_we_o !== 1'b0) begin
          errors++; $display("FAIL delay_stable: got %h %b %b want 00001004 1100 0", wb_adr_o, wb_sel_o, wb_we_o);
        end
      end
      if (!stall_req) begin hold_at = c; break; end
    end
    checks++;
    if (bus_cycles != 4 || hold_at != 5) begin
      errors++; $display("FAIL delay_timing: got %0d bus cycles hold %0d want 4 hold 5", bus_cycles, hold_at);
    end
    exp = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== exp) begin errors++; $display("FAIL delay_rdata: got %h want %h", cpu_rdata, exp); end
    end_req();
    ack_delay = 0;
  endtask

  task automatic test_back_to_back();
    ack_delay = 0; sw = 8'h77; mem_word = 32'h600D_F00D;
    drive(1'b0, SW_ADDR, 4'hF, 32'h0);
    exp_q.push_back(32'h0000_0077);
    @(negedge clk); @(negedge clk); @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (stall_req !== 1'b0 || cpu_rdata !== exp) begin
      errors++; $display("FAIL b2b_first: got stall %b data %h want 0 %h", stall_req, cpu_rdata, exp);
    end
    @(posedge clk); #1;
    cpu_addr = 32'h0000_4000;
    exp_q.push_back(32'h600D_F00D);
    @(negedge clk);
    checks++;
    if ({stall_req, wb_cyc_o} !== 2'b10) begin
      errors++; $display("FAIL b2b_gap: got %b want 10", {stall_req, wb_cyc_o});
    end
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h0000_4000) begin
      errors++; $display("FAIL b2b_second_bus: got %b %h want 1 00004000", wb_cyc_o, wb_adr_o);
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (stall_req !== 1'b0 || cpu_rdata !== exp) begin
      errors++; $display("FAIL b2b_second: got stall %b data %h want 0 %h", stall_req, cpu_rdata, exp);
    end
    end_req();
  endtask

  task automatic test_timeout();
    int cyc_cycles = 0, hold_at = -1;
    never_ack = 1'b1;
    drive(1'b0, 32'h0000_2000, 4'hF, 32'h0);
    exp_q.push_back(ERR_VAL);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wb_cyc_o) cyc_cycles++;
      if (!stall_req) begin hold_at = c; break; end
    end
    checks++;
    if (cyc_cycles != 15 || hold_at != 16) begin
      errors++; $display("FAIL timeout_timing: got %0d cyc cycles hold %0d want 15 hold 16", cyc_cycles, hold_at);
    end
    exp = exp_q.pop_front();
    checks++;
    if (bus_err !== 1'b1 || cpu_rdata !== exp) begin
      errors++; $display("FAIL timeout_hold: got err %b data %h want 1 %h", bus_err, cpu_rdata, exp);
    end
    end_req();
    never_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_err, wb_cyc_o, stall_req} !== 3'b000) begin
      errors++; $display("FAIL timeout_pulse_end: got %b want 000", {bus_err, wb_cyc_o, stall_req});
    end
  endtask

  task automatic test_flush_discard();
    int first_cyc = -1, hold_at = -1;
    ack_delay = 3; mem_word = 32'hCAFE_F00D; sw = 8'h3C;
    drive(1'b0, 32'h0000_3000, 4'hF, 32'h0);
    exp_q.push_back(32'h0000_003C);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0 || wb_cyc_o !== 1'b1) begin
      errors++; $display("FAIL flush_c2: got stall %b cyc %b want 0 1", stall_req, wb_cyc_o);
    end
    @(posedge clk); #1;
    flush = 1'b0; cpu_addr = SW_ADDR;
    @(negedge clk);
    checks++;
    if ({stall_req, wb_cyc_o} !== 2'b11 || wb_adr_o !== 32'h0000_3000) begin
      errors++; $display("FAIL flush_old_held: got %b %h want 11 00003000", {stall_req, wb_cyc_o}, wb_adr_o);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({stall_req, wb_cyc_o} !== 2'b10 || cpu_rdata !== ERR_VAL) begin
      errors++; $display("FAIL flush_no_hold: got %b data %h want 10 %h", {stall_req, wb_cyc_o}, cpu_rdata, ERR_VAL);
    end
    for (int c = 6; c < 20; c++) begin
      @(negedge clk);
      if (wb_cyc_o && first_cyc < 0) begin
        first_cyc = c;
        checks++;
        if (wb_adr_o !== SW_ADDR) begin errors++; $display("FAIL flush_new_adr: got %h want %h", wb_adr_o, SW_ADDR); end
      end
      if (!stall_req) begin hold_at = c; break; end
    end
    checks++;
    if (first_cyc != 6 || hold_at != 10) begin
      errors++; $display("FAIL flush_new_timing: got start %0d hold %0d want 6 10", first_cyc, hold_at);
    end
    exp = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== exp) begin errors++; $display("FAIL flush_new_rdata: got %h want %h", cpu_rdata, exp); end
    end_req();
    ack_delay = 0;
  endtask

  task automatic test_reset_in_bus();
    int lat; bit done;
    ack_delay = 3;
    drive(1'b1, LED_ADDR, 4'hF, 32'h1111_2222);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({wb_cyc_o, wb_we_o} !== 2'b11) begin
      errors++; $display("FAIL rstbus_pre: got %b want 11", {wb_cyc_o, wb_we_o});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0) begin errors++; $display("FAIL rstbus_stall: got %b want 0", stall_req); end
    @(posedge clk); #1;
    rst = 1'b0; cpu_ce = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, bus_err, stall_req} !== 5'b00000) begin
      errors++; $display("FAIL rstbus_after: got %b want 00000", {wb_cyc_o, wb_stb_o, wb_we_o, bus_err, stall_req});
    end
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({wb_cyc_o, bus_err} !== 2'b00 || cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL rstbus_late_ack: got %b data %h want 00 00000000", {wb_cyc_o, bus_err}, cpu_rdata);
    end
    ack_delay = 0; sw = 8'h5A;
    exp_q.push_back(32'h0000_005A);
    drive(1'b0, SW_ADDR, 4'hF, 32'h0);
    wait_hold(10, lat, done);
    exp = exp_q.pop_front();
    checks++;
    if (!done || lat != 2 || cpu_rdata !== exp) begin
      errors++; $display("FAIL rstbus_next: got lat %0d data %h want lat 2 data %h", lat, cpu_rdata, exp);
    end
    end_req();
  endtask

  initial begin
    test_reset();
    test_load_switch();
    test_store_led();
    test_delayed_ack();
    test_back_to_back();
    test_timeout();
    test_flush_discard();
    test_reset_in_bus();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
